// File: rtl/ask_baseband_gen.sv
// ASK baseband symbol generator: 1,0 preamble then PRBS-7 data, with a signed level out.
// Define ASK_RAMP_SHAPE_EN to slew mod_signal 1 LSB per clk instead of stepping it.
module ask_baseband_gen #(
    parameter int SYM_DIV = 50000,
    parameter int PRE_LEN = 8,
    parameter int LEVEL   = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic              din,
    output logic signed [6:0] mod_signal,
    output logic              sym_stb,
    output logic              busy
);

    localparam int TW = $clog2(SYM_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(SYM_DIV - 1);
    localparam logic [7:0] P_LAST = 8'(PRE_LEN - 1);
    localparam logic signed [6:0] LV_P = 7'(LEVEL);
    localparam logic signed [6:0] LV_N = 7'(-LEVEL);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        pre_q, pre_d;
    logic [6:0]        lfsr_q, lfsr_d;
    logic              stop_req_q, stop_req_d;
    logic              din_d, busy_d, sym_stb_d;
    logic signed [6:0] mod_d;
    logic              bnd;
    logic [6:0]        lfsr_sh;

    assign bnd     = (state_q != IDLE) && (timer_q == T_LAST);
    assign lfsr_sh = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pre_d      = pre_q;
        lfsr_d     = lfsr_q;
        stop_req_d = stop_req_q;
        din_d      = din;
        unique case (state_q)
            IDLE: begin
                timer_d    = '0;
                stop_req_d = 1'b0;
                if (start) begin
                    state_d = PREAMBLE;
                    din_d   = 1'b1;
                    pre_d   = '0;
                    lfsr_d  = 7'h7F;
                end
            end
            PREAMBLE, DATA: begin
                timer_d = bnd ? '0 : timer_q + TW'(1);
                if (stop) stop_req_d = 1'b1;
                if (bnd) begin
                    if (stop_req_q) begin
                        state_d    = IDLE;
                        din_d      = 1'b0;
                        stop_req_d = 1'b0;
                    end else if (state_q == PREAMBLE && pre_q != P_LAST) begin
                        din_d = ~din;
                        pre_d = pre_q + 8'd1;
                    end else begin
                        // Entry into DATA already consumes the first PRBS bit
                        state_d = DATA;
                        din_d   = lfsr_q[6];
                        lfsr_d  = lfsr_sh;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d    = (state_d != IDLE);
    assign sym_stb_d = busy_d && (timer_d == T_LAST);

`ifdef ASK_RAMP_SHAPE_EN
    logic signed [6:0] tgt;

    assign tgt = busy ? (din ? LV_P : LV_N) : 7'sd0;

    always_comb begin
        mod_d = mod_signal;
        if (mod_signal < tgt) begin
            mod_d = mod_signal + 7'sd1;
        end else if (mod_signal > tgt) begin
            mod_d = mod_signal - 7'sd1;
        end
    end
`else
    assign mod_d = busy_d ? (din_d ? LV_P : LV_N) : 7'sd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pre_q      <= '0;
            lfsr_q     <= 7'h7F;
            stop_req_q <= 1'b0;
            din        <= 1'b0;
            mod_signal <= '0;
            sym_stb    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pre_q      <= pre_d;
            lfsr_q     <= lfsr_d;
            stop_req_q <= stop_req_d;
            din        <= din_d;
            mod_signal <= mod_d;
            sym_stb    <= sym_stb_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ask_baseband_gen.sv
// Self-checking bench for ask_baseband_gen: symbol table plus scoreboard of per-symbol expectations.
// Ramp checks are built in when ASK_RAMP_SHAPE_EN is defined.
module tb_ask_baseband_gen;

    localparam int SD = 16;
    localparam int PL = 4;
    localparam int LV = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              din;
    logic signed [6:0] mod_signal;
    logic              sym_stb;
    logic              busy;

    ask_baseband_gen #(
        .SYM_DIV(SD),
        .PRE_LEN(PL),
        .LEVEL  (LV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .din       (din),
        .mod_signal(mod_signal),
        .sym_stb   (sym_stb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit d;
        int m;
    } vec_t;

    vec_t vecs[12];
    vec_t sbq[$];
    bit   gen[127];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pops = 0;
    int last_stb = -1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit d);
        vec_t v;
        v.d = d;
        v.m = d ? LV : -LV;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard side: each sym_stb retires one expected symbol
    always @(negedge clk) begin
        vec_t e;
        if (!busy) last_stb = -1;
`ifndef ASK_RAMP_SHAPE_EN
        if (busy && int'(mod_signal) != (din ? LV : -LV))
            chk("mod_vs_din", int'(mod_signal), din ? LV : -LV);
`endif
        if (sym_stb) begin
            chk("stb_busy", int'(busy), 1);
            if (last_stb >= 0) chk("stb_period", cyc - last_stb, SD);
            last_stb = cyc;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stb_unexpected: got sym_stb=1 expected no symbol");
            end else begin
                e = sbq.pop_front();
                chk("sym_din", int'(din), int'(e.d));
                chk("sym_mod", int'(mod_signal), e.m);
                pops++;
            end
        end
    end

    task automatic wait_pops(input int n, input int budget);
        int t = 0;
        while (pops < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("pops_reached", pops, n);
    endtask

    task automatic pulse(input bit s, input bit p);
        @(negedge clk);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] l;
        int stb_seen;
        int t;
        int p;
        bit pre[4] = '{1, 0, 1, 0};
        bit dat[8] = '{1, 1, 1, 1, 1, 1, 1, 0};

        for (int i = 0; i < 4; i++) vecs[i] = mk(pre[i]);
        for (int i = 0; i < 8; i++) vecs[4 + i] = mk(dat[i]);
        l = 7'h7F;
        for (int k = 0; k < 127; k++) begin
            gen[k] = l[6];
            l = {l[5:0], l[6] ^ l[5]};
        end

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_din", int'(din), 0);
        chk("rst_mod", int'(mod_signal), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stb", int'(sym_stb), 0);
        rst_n = 1'b1;

        stb_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (sym_stb || busy) stb_seen++;
        end
        chk("idle_activity", stb_seen, 0);
        chk("idle_din", int'(din), 0);
        chk("idle_mod", int'(mod_signal), 0);

        // Long burst: preamble, full PRBS period, repeat of its head, then stop
        for (int i = 0; i < 12; i++) sbq.push_back(vecs[i]);
        for (int k = 8; k < 127; k++) sbq.push_back(mk(gen[k]));
        for (int i = 4; i < 12; i++) sbq.push_back(vecs[i]);
        sbq.push_back(mk(gen[8]));
        pulse(1'b1, 1'b0);
        chk("start_busy", int'(busy), 1);
        chk("start_din", int'(din), 1);
        wait_pops(139, 139 * SD + 40);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (11) @(negedge clk);
        chk("stop_busy_c12", int'(busy), 1);
        @(negedge clk);
        chk("stop_busy_c13", int'(busy), 0);
        chk("stop_din", int'(din), 0);
`ifndef ASK_RAMP_SHAPE_EN
        chk("stop_mod", int'(mod_signal), 0);
`else
        t = 0;
        while (mod_signal != 0 && t < 2 * LV + 2) begin
            @(negedge clk);
            t++;
        end
        chk("stop_mod_ramped", int'(mod_signal), 0);
`endif
        chk("sbq_after_long", sbq.size(), 0);

`ifdef ASK_RAMP_SHAPE_EN
        p = pops;
        sbq.push_back(vecs[0]);
        sbq.push_back(vecs[1]);
        pulse(1'b1, 1'b0);
        wait_pops(p + 1, SD + 8);
        for (int j = 0; j <= 2 * LV; j++) begin
            @(negedge clk);
            chk("ramp_step", int'(mod_signal), LV - j);
        end
        repeat (3) begin
            @(negedge clk);
            chk("ramp_hold", int'(mod_signal), -LV);
        end
        pulse(1'b0, 1'b1);
        wait_pops(p + 2, SD + 8);
        @(negedge clk);
        chk("ramp_stop_busy", int'(busy), 0);
        repeat (2 * LV + 2) @(negedge clk);
        chk("ramp_stop_mod", int'(mod_signal), 0);
`endif

        // start+stop together while busy: ends at the boundary, no restart
        p = pops;
        sbq.push_back(vecs[0]);
        pulse(1'b1, 1'b0);
        chk("b2_busy", int'(busy), 1);
        repeat (4) @(negedge clk);
        pulse(1'b1, 1'b1);
        wait_pops(p + 1, SD + 8);
        @(negedge clk);
        chk("both_busy_end", int'(busy), 0);
        repeat (20) @(negedge clk);
        chk("both_no_restart", int'(busy), 0);

        // start+stop together in IDLE: start wins, stop is not remembered
        p = pops;
        sbq.push_back(vecs[0]);
        sbq.push_back(vecs[1]);
        sbq.push_back(vecs[2]);
        pulse(1'b1, 1'b1);
        chk("idle_both_busy", int'(busy), 1);
        chk("idle_both_din", int'(din), 1);
        wait_pops(p + 3, 3 * SD + 8);

        // Asynchronous reset mid-burst
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_din", int'(din), 0);
        chk("arst_mod", int'(mod_signal), 0);
        chk("arst_stb", int'(sym_stb), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_din", int'(din), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ask_baseband_gen.md
ASK_BASEBAND_GEN -- requirements
Module: ask_baseband_gen

Interface
REQ-001 SHALL have parameter SYM_DIV, default 50000: clk cycles per symbol; legal range >= 2*LEVEL+4.
REQ-002 SHALL have parameter PRE_LEN, default 8: number of preamble symbols, 1..255.
REQ-003 SHALL have parameter LEVEL, default 63: magnitude of the modulating level, 1..63.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: level-sampled request to begin a burst.
REQ-007 SHALL have port stop, input, 1 bit: level-sampled request to end a burst at the next symbol boundary.
REQ-008 SHALL have port din, output, 1 bit: current binary symbol, registered.
REQ-009 SHALL have port mod_signal, output, 7 bits, signed two's complement: modulating level fed to the AM adder.
REQ-010 SHALL have port sym_stb, output, 1 bit: one-cycle pulse on the last cycle of each symbol.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, PREAMBLE and DATA, with all outputs registered.
REQ-013 SHALL count symbol timer 0..SYM_DIV-1 while busy, wrap to 0, and hold it at 0 in IDLE.
REQ-014 SHALL assert sym_stb exactly when busy and timer==SYM_DIV-1; the new symbol takes effect at the following edge.
REQ-015 SHALL, on start=1 in IDLE, move to PREAMBLE at the next edge with din=1, timer=0, preamble count=0, and LFSR=7'h7F.
REQ-016 SHALL toggle din at each symbol boundary in PREAMBLE, so the preamble pattern is 1,0,1,0...
REQ-017 SHALL enter DATA after PRE_LEN preamble symbols, emitting din=lfsr[6] and then shifting lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]} at every DATA boundary (PRBS-7, period 127).
REQ-018 SHALL set a stop_req flag when stop=1 while busy; at the next boundary go to IDLE, set din=0, and clear stop_req.
REQ-019 SHALL ignore start while busy, and ignore stop while in IDLE.
REQ-020 SHALL give stop priority when start and stop are both high while busy; in IDLE with both high, start wins.
REQ-021 SHALL drive the target level as +LEVEL when din=1 and -LEVEL when din=0 while busy, and 0 in IDLE.
REQ-022 SHALL, without the Configuration macro, set mod_signal equal to the target at the same edge din changes.

Reset
REQ-023 SHALL, on rst_n low and asynchronously, force state=IDLE, timer=0, din=0, mod_signal=0, sym_stb=0, busy=0, stop_req=0, lfsr=7'h7F.
REQ-024 SHALL, on reset mid-burst, abort immediately; after release the block idles until a new start.

Configuration
REQ-025 SHALL, when macro ASK_RAMP_SHAPE_EN is defined, slew mod_signal toward the target by exactly 1 LSB per clk and stop at the target with no overshoot.
REQ-026 SHALL, when ASK_RAMP_SHAPE_EN is defined, make a full swing from -LEVEL to +LEVEL take 2*LEVEL cycles and ramp to 0 after stop.
REQ-027 SHALL, when ASK_RAMP_SHAPE_EN is undefined, use the instantaneous step of REQ-022 with no ramp logic present.

Verification (SYM_DIV=16, PRE_LEN=4, LEVEL=5 unless stated)
REQ-028 SHALL cover: reset released, no start for 100 cycles -> din=0, mod_signal=0, busy=0, sym_stb never high.
REQ-029 SHALL cover: 1-cycle start -> busy high next cycle; din over first 4 symbols = 1,0,1,0; sym_stb every 16 cycles.
REQ-030 SHALL cover: continue after preamble -> DATA bits 1,1,1,1,1,1,1,0; after 127 DATA symbols the sequence repeats.
REQ-031 SHALL cover: stop pulse at timer=3 of a DATA symbol -> symbol completes; 13 cycles later busy=0, din=0, mod_signal=0.
REQ-032 SHALL cover: start and stop high together while busy -> burst ends at boundary with no restart; both high in IDLE -> burst starts.
REQ-033 SHALL cover, with ASK_RAMP_SHAPE_EN: a 1->0 symbol transition -> mod_signal steps 5,4,...,-5 over 10 cycles, then holds at -5.
